unified_sram_arbiter: RTL and testbench
=======================================

Name: unified_sram_arbiter

Overview:
- Shares one synchronous single-port SRAM between the instruction-fetch requester (pc_reg/if_id side) and the data requester (mem stage).
- Sequences every access: issue → fixed-latency wait → one-cycle ack with read data.
- Raises per-requester stall requests toward ctrl while an access is pending.
- Data side has priority, with a bounded-starvation guarantee for fetch.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width (fixed at 32; byte strobes are 4 bits)
MEM_LAT, 1, SRAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..7
DATA_BURST_MAX, 4, maximum consecutive data grants while fetch waits; legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request; held high until inst_ack
inst_addr  in  ADDR_W  fetch address; stable while inst_req is high
inst_ack  out  1  one-cycle pulse; fetch complete
inst_rdata  out  DATA_W  fetch data; equals mem_rdata when inst_ack, else 0
data_req  in  1  data request; held high until data_ack
data_wen  in  4  byte write strobes; 4'b0000 = read
data_addr  in  ADDR_W  data address; stable while data_req is high
data_wdata  in  DATA_W  store data; stable while data_req is high
data_ack  out  1  one-cycle pulse; data access complete
data_rdata  out  DATA_W  load data; equals mem_rdata when data_ack, else 0
stallreq_if  out  1  inst_req & ~inst_ack; forced 0 in reset
stallreq_mem  out  1  data_req & ~data_ack; forced 0 in reset
mem_en  out  1  SRAM enable; high for exactly the issue cycle
mem_wen  out  4  SRAM byte write enables; data_wen on a data issue, 0 otherwise
mem_addr  out  ADDR_W  granted address on the issue cycle, 0 otherwise
mem_wdata  out  DATA_W  data_wdata on a data issue, 0 otherwise
mem_rdata  in  DATA_W  SRAM read data, valid MEM_LAT cycles after issue

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE, owner = none, wait counter = 0, burst counter = 0.
  - All outputs 0 while rstn is low.
- States: IDLE, BUSY.
- IDLE, no request: mem_en = 0; stay in IDLE.
- IDLE, at least one request present: issue combinationally in the same cycle T.
  - Drive mem_en = 1 and the owner's addr/wen/wdata (mem_wen = 0 for a fetch).
  - Register owner; load wait counter with MEM_LAT; go to BUSY.
- Grant choice in IDLE:
  - Only one request present: grant it.
  - Both present: grant data unless burst counter == DATA_BURST_MAX, in which case grant inst.
- Burst counter:
  - Increments on a data grant when inst_req is high in that cycle.
  - Clears on any inst grant.
  - Clears on a data grant when inst_req is low.
  - Saturates at DATA_BURST_MAX.
- BUSY:
  - Wait counter decrements each cycle.
  - In the cycle the counter reaches 0 (cycle T+MEM_LAT): pulse the owner's ack, present mem_rdata on the owner's rdata, return to IDLE.
  - mem_en = 0 throughout BUSY; no new issue in the ack cycle.
  - Next issue is therefore at the earliest T+MEM_LAT+1: one access per MEM_LAT+1 cycles.
- Writes follow the same timing as reads; ack at T+MEM_LAT; rdata = mem_rdata (don't care, but deterministic pass-through).
- Requests arriving during BUSY wait. Stall outputs stay high for them.
- A request dropped before its ack is a protocol violation. The in-flight access still completes and the ack still pulses.
- Reset mid-BUSY: transaction abandoned, no ack produced. After rstn rises, state is IDLE; pending requests re-arbitrate from scratch with burst counter 0.
- rdata outputs are combinational gates of mem_rdata (no extra register). Ack outputs are decoded from registered state.

Test Plan:
- Single fetch, MEM_LAT=1: inst_req=1 at T, inst_addr=0xBFC00000 → mem_en=1, mem_addr=0xBFC00000, mem_wen=0 at T; inst_ack=1 at T+1 with inst_rdata=mem_rdata=0x24080001; stallreq_if high at T, low at T+1.
- Simultaneous fetch and load at T → data granted at T, data_ack at T+1; inst issued at T+2, inst_ack at T+3.
- Starvation bound, DATA_BURST_MAX=4, data_req and inst_req held continuously → grant sequence D,D,D,D,I,D,D,D,D,I; issues every 2 cycles.
- Byte store, data_wen=4'b0011, data_addr=0x00001004, data_wdata=0xDEADBEEF → at issue: mem_wen=4'b0011, mem_addr=0x00001004, mem_wdata=0xDEADBEEF; data_ack one cycle later; no inst_ack.
- MEM_LAT=3: data issue at T → mem_en only at T; data_ack exactly at T+3; next issue no earlier than T+4.
- rstn pulsed low at T+1 of a MEM_LAT=3 fetch → all outputs 0 immediately; no inst_ack; fetch re-issued on the first cycle after rstn rises with inst_req still high.

Source files
------------

// File: rtl/unified_sram_arbiter.sv
// unified_sram_arbiter
// Shares one synchronous single-port SRAM between the instruction-fetch
// requester and the data (mem stage) requester. Each access is issued
// combinationally from IDLE, waits MEM_LAT cycles in BUSY, then returns a
// one-cycle ack carrying mem_rdata. Data wins ties, but after
// DATA_BURST_MAX back-to-back data grants with fetch waiting, fetch gets
// the next slot.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   inst_req/addr -> ack/rdata     fetch requester (req held until ack)
//   data_req/wen/addr/wdata -> ack/rdata   data requester (wen 0 = read)
//   stallreq_if, stallreq_mem  pending-access stall requests toward ctrl
//   mem_en/wen/addr/wdata, mem_rdata   SRAM port (en high on issue cycle)
module unified_sram_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MEM_LAT        = 1,
   parameter int DATA_BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_ack,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic [3:0]        data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_ack,
   output logic [DATA_W-1:0] data_rdata,
   output logic              stallreq_if,
   output logic              stallreq_mem,
   output logic              mem_en,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [2:0] LAT  = 3'(MEM_LAT);
   localparam logic [3:0] BMAX = 4'(DATA_BURST_MAX);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic       owner_d;   // 1: data owns the in-flight access
   logic [2:0] wcnt;      // cycles left until the ack edge
   logic [3:0] bcnt;      // consecutive data grants while fetch waited

   logic any_req, grant_d, issue, ack;

   assign any_req = inst_req | data_req;
   // Data wins unless fetch has already been passed over BMAX times.
   assign grant_d = data_req & ~(inst_req & (bcnt == BMAX));
   // Gating with rstn keeps every output at 0 during reset, even though
   // the issue path is combinational from the request inputs.
   assign issue   = rstn & (state == IDLE) & any_req;
   // wcnt is loaded with MEM_LAT at issue and steps to 0 on the edge that
   // ends the ack cycle, so the ack cycle is the one where it still reads 1.
   assign ack     = rstn & (state == BUSY) & (wcnt == 3'd1);

   assign mem_en    = issue;
   assign mem_wen   = (issue & grant_d) ? data_wen : 4'b0000;
   assign mem_addr  = issue ? (grant_d ? data_addr : inst_addr) : '0;
   assign mem_wdata = (issue & grant_d) ? data_wdata : '0;

   assign inst_ack   = ack & ~owner_d;
   assign data_ack   = ack & owner_d;
   assign inst_rdata = inst_ack ? mem_rdata : '0;
   assign data_rdata = data_ack ? mem_rdata : '0;

   assign stallreq_if  = rstn & inst_req & ~inst_ack;
   assign stallreq_mem = rstn & data_req & ~data_ack;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         wcnt    <= 3'd0;
         bcnt    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state   <= BUSY;
                  owner_d <= grant_d;
                  wcnt    <= LAT;
                  // Only a data grant that made fetch wait extends the burst.
                  if (grant_d & inst_req) begin
                     if (bcnt != BMAX) bcnt <= bcnt + 4'd1;
                  end else begin
                     bcnt <= 4'd0;
                  end
               end
            end
            BUSY: begin
               wcnt <= wcnt - 3'd1;
               if (wcnt == 3'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// Bench for unified_sram_arbiter: two instances (MEM_LAT 1 and 3), each with
// directed scenarios, a randomized requester phase, and a cycle-level
// behavioural model compared on every falling edge.
module tb_unified_sram_arbiter;

   localparam int BMAX = 4;
   localparam logic [31:0] A_I  = 32'hBFC0_0000;
   localparam logic [31:0] A_I2 = 32'hBFC0_0040;
   localparam logic [31:0] A_D  = 32'h1000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input int lat, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL lat%0d %s: got %0h expected %0h at %0t", lat, nm, act, exp, $time);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lat
      localparam int LAT = (g == 0) ? 1 : 3;

      logic        rstn;
      logic        inst_req;
      logic [31:0] inst_addr;
      logic        inst_ack;
      logic [31:0] inst_rdata;
      logic        data_req;
      logic [3:0]  data_wen;
      logic [31:0] data_addr;
      logic [31:0] data_wdata;
      logic        data_ack;
      logic [31:0] data_rdata;
      logic        stallreq_if;
      logic        stallreq_mem;
      logic        mem_en;
      logic [3:0]  mem_wen;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [31:0] mem_rdata;

      bit done = 1'b0;
      bit ia_seen = 1'b0;
      bit da_seen = 1'b0;

      unified_sram_arbiter #(
         .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .DATA_BURST_MAX(BMAX)
      ) dut (
         .clk(clk), .rstn(rstn),
         .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
         .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
         .data_ack(data_ack), .data_rdata(data_rdata),
         .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
         .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
         .mem_rdata(mem_rdata)
      );

      // Behavioural model: an access issued at cycle c acks at cycle c+LAT;
      // data wins unless it has already been chosen BMAX times in a row over
      // a waiting fetch.
      initial begin : model
         bit busy, own_d, gd, acked;
         int iss, burst, cyc;
         logic e_en, e_ia, e_da;
         logic [3:0] e_wen;
         logic [31:0] e_addr, e_wdata;
         busy = 0; own_d = 0; iss = 0; burst = 0; cyc = 0;
         forever begin
            @(negedge clk);
            cyc++;
            e_en = 0; e_ia = 0; e_da = 0; e_wen = 4'b0; e_addr = 32'h0; e_wdata = 32'h0;
            if (!rstn) begin
               busy = 0;
               burst = 0;
            end else if (busy) begin
               acked = (cyc == iss + LAT);
               e_ia = acked && !own_d;
               e_da = acked && own_d;
               if (acked) busy = 0;
            end else if (inst_req || data_req) begin
               gd = data_req && !(inst_req && burst == BMAX);
               e_en = 1;
               e_addr = gd ? data_addr : inst_addr;
               e_wen = gd ? data_wen : 4'b0;
               e_wdata = gd ? data_wdata : 32'h0;
               busy = 1; iss = cyc; own_d = gd;
               if (gd && inst_req) burst = (burst < BMAX) ? burst + 1 : BMAX;
               else burst = 0;
            end
            chk(LAT, "m_mem_en", 64'(mem_en), 64'(e_en));
            chk(LAT, "m_mem_addr", 64'(mem_addr), 64'(e_addr));
            chk(LAT, "m_mem_wen", 64'(mem_wen), 64'(e_wen));
            chk(LAT, "m_mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            chk(LAT, "m_inst_ack", 64'(inst_ack), 64'(e_ia));
            chk(LAT, "m_data_ack", 64'(data_ack), 64'(e_da));
            chk(LAT, "m_inst_rdata", 64'(inst_rdata), 64'(e_ia ? mem_rdata : 32'h0));
            chk(LAT, "m_data_rdata", 64'(data_rdata), 64'(e_da ? mem_rdata : 32'h0));
            chk(LAT, "m_stall_if", 64'(stallreq_if), 64'(rstn && inst_req && !e_ia));
            chk(LAT, "m_stall_mem", 64'(stallreq_mem), 64'(rstn && data_req && !e_da));
            ia_seen = inst_ack;
            da_seen = data_ack;
         end
      end

      // Advance until the requested ack shows up; mem_en must stay low meanwhile.
      task automatic wait_ack(input bit is_d, output int n);
         n = 0;
         do begin
            adv();
            n++;
            if (!(is_d ? data_ack : inst_ack)) chk(LAT, "en_while_busy", 64'(mem_en), 64'd0);
         end while (!(is_d ? data_ack : inst_ack) && n < 12);
      endtask

      initial begin : stim
         int n;
         logic [9:0] seq;
         seq = 10'b10_0001_0000;  // bit i set: grant i goes to fetch
         rstn = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wen = 0;
         data_addr = 0; data_wdata = 0; mem_rdata = 0;

         // Reset state, with requests asserted to show they are masked.
         adv(); adv();
         inst_req = 1; data_req = 1; inst_addr = A_I; data_addr = A_D; #1;
         chk(LAT, "rst_mem_en", 64'(mem_en), 64'd0);
         chk(LAT, "rst_mem_addr", 64'(mem_addr), 64'd0);
         chk(LAT, "rst_stall_if", 64'(stallreq_if), 64'd0);
         chk(LAT, "rst_stall_mem", 64'(stallreq_mem), 64'd0);
         inst_req = 0; data_req = 0;
         adv(); rstn = 1;

         // Single fetch.
         adv(); inst_req = 1; inst_addr = A_I; mem_rdata = 32'h2408_0001; #1;
         chk(LAT, "f_en", 64'(mem_en), 64'd1);
         chk(LAT, "f_addr", 64'(mem_addr), 64'(A_I));
         chk(LAT, "f_wen", 64'(mem_wen), 64'd0);
         chk(LAT, "f_stall_hi", 64'(stallreq_if), 64'd1);
         wait_ack(0, n);
         chk(LAT, "f_lat", 64'(n), 64'(LAT));
         chk(LAT, "f_rdata", 64'(inst_rdata), 64'h2408_0001);
         chk(LAT, "f_stall_lo", 64'(stallreq_if), 64'd0);
         adv(); inst_req = 0; #1;

         // Simultaneous fetch and load: data first, fetch right after.
         adv(); inst_req = 1; inst_addr = A_I2; data_req = 1; data_addr = A_D; data_wen = 0;
         mem_rdata = 32'h1234_5678; #1;
         chk(LAT, "s_addr_d", 64'(mem_addr), 64'(A_D));
         wait_ack(1, n);
         chk(LAT, "s_dlat", 64'(n), 64'(LAT));
         chk(LAT, "s_drdata", 64'(data_rdata), 64'h1234_5678);
         chk(LAT, "s_no_iack", 64'(inst_ack), 64'd0);
         chk(LAT, "s_stall_if", 64'(stallreq_if), 64'd1);
         chk(LAT, "s_stall_mem", 64'(stallreq_mem), 64'd0);
         adv(); data_req = 0; #1;
         chk(LAT, "s_i_en", 64'(mem_en), 64'd1);
         chk(LAT, "s_i_addr", 64'(mem_addr), 64'(A_I2));
         wait_ack(0, n);
         chk(LAT, "s_ilat", 64'(n), 64'(LAT));
         adv(); inst_req = 0; #1;

         // Byte store.
         adv(); data_req = 1; data_wen = 4'b0011; data_addr = 32'h0000_1004;
         data_wdata = 32'hDEAD_BEEF; #1;
         chk(LAT, "w_en", 64'(mem_en), 64'd1);
         chk(LAT, "w_wen", 64'(mem_wen), 64'd3);
         chk(LAT, "w_addr", 64'(mem_addr), 64'h1004);
         chk(LAT, "w_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
         wait_ack(1, n);
         chk(LAT, "w_lat", 64'(n), 64'(LAT));
         chk(LAT, "w_no_iack", 64'(inst_ack), 64'd0);
         adv(); data_req = 0; data_wen = 0; data_wdata = 0; #1;

         // Starvation bound with both requesters held continuously.
         adv(); inst_req = 1; inst_addr = A_I; data_req = 1; data_addr = A_D; #1;
         for (int i = 0; i < 10; i++) begin
            chk(LAT, "b_en", 64'(mem_en), 64'd1);
            chk(LAT, "b_grant_inst", 64'(mem_addr == A_I), 64'(seq[i]));
            if (i < 9) begin
               n = 0;
               do begin adv(); n++; end while (!mem_en && n < 12);
               chk(LAT, "b_gap", 64'(n), 64'(LAT + 1));
            end
         end
         wait_ack(0, n);
         chk(LAT, "b_last_lat", 64'(n), 64'(LAT));
         adv(); inst_req = 0; data_req = 0; #1;

         // Reset in the middle of a fetch.
         adv(); inst_req = 1; inst_addr = A_I; #1;
         chk(LAT, "r_en", 64'(mem_en), 64'd1);
         adv(); rstn = 0; #1;
         chk(LAT, "r_en0", 64'(mem_en), 64'd0);
         chk(LAT, "r_addr0", 64'(mem_addr), 64'd0);
         chk(LAT, "r_iack0", 64'(inst_ack), 64'd0);
         chk(LAT, "r_stall0", 64'(stallreq_if), 64'd0);
         adv();
         chk(LAT, "r_iack_hold", 64'(inst_ack), 64'd0);
         adv(); rstn = 1; #1;
         chk(LAT, "r_reissue", 64'(mem_en), 64'd1);
         chk(LAT, "r_readdr", 64'(mem_addr), 64'(A_I));
         wait_ack(0, n);
         chk(LAT, "r_lat", 64'(n), 64'(LAT));
         adv(); inst_req = 0; #1;

         // Randomized requesters; a request is held until its ack.
         for (int c = 0; c < 3000; c++) begin
            adv();
            mem_rdata = $urandom;
            rstn = ($urandom_range(0, 299) != 0);
            if (inst_req) begin
               if (ia_seen) begin
                  if ($urandom_range(0, 1) == 1) inst_req = 0;
                  else inst_addr = $urandom;
               end
            end else if ($urandom_range(0, 1) == 1) begin
               inst_req = 1; inst_addr = $urandom;
            end
            if (data_req) begin
               if (da_seen) begin
                  if ($urandom_range(0, 2) == 0) data_req = 0;
                  else begin
                     data_addr = $urandom; data_wdata = $urandom;
                     data_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
                  end
               end
            end else if ($urandom_range(0, 1) == 1) begin
               data_req = 1; data_addr = $urandom; data_wdata = $urandom;
               data_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
            end
         end
         adv(); rstn = 1; inst_req = 0; data_req = 0;
         adv(); adv();
         done = 1;
      end
   end

   initial begin : finale
      int t;
      t = 0;
      while (!(g_lat[0].done && g_lat[1].done) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      chk(0, "all_done", 64'({g_lat[0].done, g_lat[1].done}), 64'd3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
